// File: rtl/exec_flag_unit.sv
// ---------------------------------------------------------------------------
// exec_flag_unit
//
// Back end of the execute stage. It takes one ALU result per cycle together
// with its {N,Z,V,C} flags. It does three things:
//   - keeps the architectural status register,
//   - resolves conditional branches against the committed status,
//   - buffers {result, rd, wr_en} in a 2-entry in-order FIFO toward writeback.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   upstream handshake; in_ready depends only on the
//                       FIFO occupancy and flush
//   in_result, in_flags ALU result and {N,Z,V,C}
//   in_set_flags        accepted instruction writes the status register
//   in_wr_en, in_rd     register write enable / destination index
//   in_is_branch        accepted instruction is a conditional branch
//   in_cond, in_target  branch condition code and target address
//   flush               empty the FIFO and cancel a pending taken pulse
//   out_valid/out_ready writeback handshake
//   out_result, out_rd, out_wr_en   head entry, driven straight from registers
//   status              committed {N,Z,V,C}
//   branch_taken        one-cycle pulse after a taken branch is accepted
//   branch_target       target address, meaningful while branch_taken=1
//   retire_count        number of entries handed to writeback (wraps)
// ---------------------------------------------------------------------------
module exec_flag_unit #(
    parameter int N    = 8,
    parameter int REGW = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    in_result,
    input  logic [3:0]      in_flags,
    input  logic            in_set_flags,
    input  logic            in_wr_en,
    input  logic [REGW-1:0] in_rd,
    input  logic            in_is_branch,
    input  logic [3:0]      in_cond,
    input  logic [N-1:0]    in_target,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_result,
    output logic [REGW-1:0] out_rd,
    output logic            out_wr_en,
    output logic [3:0]      status,
    output logic            branch_taken,
    output logic [N-1:0]    branch_target,
    output logic [15:0]     retire_count
);

    // FIFO occupancy: 0, 1 or 2 entries. The head entry lives in the
    // out_* registers so writeback sees registered values; the tail holds
    // the second entry while writeback is stalled.
    logic [1:0]      count_reg, count_next;
    logic [N-1:0]    head_result_reg, head_result_next;
    logic [REGW-1:0] head_rd_reg, head_rd_next;
    logic            head_wr_en_reg, head_wr_en_next;
    logic [N-1:0]    tail_result_reg, tail_result_next;
    logic [REGW-1:0] tail_rd_reg, tail_rd_next;
    logic            tail_wr_en_reg, tail_wr_en_next;

    logic [3:0]      status_reg, status_next;
    logic            taken_reg, taken_next;
    logic [N-1:0]    target_reg, target_next;
    logic [15:0]     retire_reg, retire_next;

    logic            accept;
    logic            pop;

    // Condition evaluation against a flag vector {N,Z,V,C}.
    function automatic logic cond_met(input logic [3:0] cond, input logic [3:0] f);
        logic fn, fz, fv, fc;
        fn = f[3];
        fz = f[2];
        fv = f[1];
        fc = f[0];
        case (cond)
            4'b0000: cond_met = 1'b1;
            4'b0001: cond_met = fz;
            4'b0010: cond_met = ~fz;
            4'b0011: cond_met = fn ^ fv;
            4'b0100: cond_met = ~(fn ^ fv);
            4'b0101: cond_met = ~fz & ~(fn ^ fv);
            4'b0110: cond_met = fz | (fn ^ fv);
            4'b0111: cond_met = fc;
            4'b1000: cond_met = ~fc;
            4'b1001: cond_met = fn;
            4'b1010: cond_met = ~fn;
            default: cond_met = 1'b0;
        endcase
    endfunction

    assign in_ready = (count_reg < 2'd2) & ~flush;
    assign accept   = in_valid & in_ready;
    assign pop      = (count_reg != 2'd0) & out_ready;

    always_comb begin
        count_next       = count_reg;
        head_result_next = head_result_reg;
        head_rd_next     = head_rd_reg;
        head_wr_en_next  = head_wr_en_reg;
        tail_result_next = tail_result_reg;
        tail_rd_next     = tail_rd_reg;
        tail_wr_en_next  = tail_wr_en_reg;

        if (flush) begin
            // Head registers keep their last value so out_* never go X.
            count_next = 2'd0;
        end else begin
            case (count_reg)
                2'd0: begin
                    if (accept) begin
                        head_result_next = in_result;
                        head_rd_next     = in_rd;
                        head_wr_en_next  = in_wr_en;
                        count_next       = 2'd1;
                    end
                end
                2'd1: begin
                    if (accept && pop) begin
                        // Head leaves while the new entry takes its place.
                        head_result_next = in_result;
                        head_rd_next     = in_rd;
                        head_wr_en_next  = in_wr_en;
                    end else if (accept) begin
                        tail_result_next = in_result;
                        tail_rd_next     = in_rd;
                        tail_wr_en_next  = in_wr_en;
                        count_next       = 2'd2;
                    end else if (pop) begin
                        count_next = 2'd0;
                    end
                end
                default: begin
                    // Full: in_ready is low, so only a pop can happen.
                    if (pop) begin
                        head_result_next = tail_result_reg;
                        head_rd_next     = tail_rd_reg;
                        head_wr_en_next  = tail_wr_en_reg;
                        count_next       = 2'd1;
                    end
                end
            endcase
        end
    end

    // Branches see status_reg as it was before this instruction's own
    // flag update, because both are evaluated from the same pre-edge state.
    always_comb begin
        taken_next  = accept & in_is_branch & cond_met(in_cond, status_reg);
        target_next = taken_next ? in_target : target_reg;
        status_next = (accept & in_set_flags) ? in_flags : status_reg;
        // A pop during a flush cycle still counts as retired.
        retire_next = pop ? retire_reg + 16'd1 : retire_reg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg       <= 2'd0;
            head_result_reg <= '0;
            head_rd_reg     <= '0;
            head_wr_en_reg  <= 1'b0;
            tail_result_reg <= '0;
            tail_rd_reg     <= '0;
            tail_wr_en_reg  <= 1'b0;
            status_reg      <= 4'b0000;
            taken_reg       <= 1'b0;
            target_reg      <= '0;
            retire_reg      <= 16'd0;
        end else begin
            count_reg       <= count_next;
            head_result_reg <= head_result_next;
            head_rd_reg     <= head_rd_next;
            head_wr_en_reg  <= head_wr_en_next;
            tail_result_reg <= tail_result_next;
            tail_rd_reg     <= tail_rd_next;
            tail_wr_en_reg  <= tail_wr_en_next;
            status_reg      <= status_next;
            taken_reg       <= taken_next;
            target_reg      <= target_next;
            retire_reg      <= retire_next;
        end
    end

    assign out_valid     = (count_reg != 2'd0);
    assign out_result    = head_result_reg;
    assign out_rd        = head_rd_reg;
    assign out_wr_en     = head_wr_en_reg;
    assign status        = status_reg;
    assign branch_taken  = taken_reg;
    assign branch_target = target_reg;
    assign retire_count  = retire_reg;

endmodule

// File: tb/tb_exec_flag_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_flag_unit
//
// Self-checking bench for exec_flag_unit. A behavioural model (queue of
// entries, status, retire counter, pending branch) is advanced once per clock
// from the same inputs the DUT sees. Each scenario task compares DUT outputs
// against the model and against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_exec_flag_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_result;
    logic [3:0] in_flags;
    logic       in_set_flags;
    logic       in_wr_en;
    logic [3:0] in_rd;
    logic       in_is_branch;
    logic [3:0] in_cond;
    logic [7:0] in_target;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_result;
    logic [3:0] out_rd;
    logic       out_wr_en;
    logic [3:0] status;
    logic       branch_taken;
    logic [7:0] branch_target;
    logic [15:0] retire_count;

    exec_flag_unit #(.N(8), .REGW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_set_flags(in_set_flags),
        .in_wr_en(in_wr_en), .in_rd(in_rd), .in_is_branch(in_is_branch),
        .in_cond(in_cond), .in_target(in_target), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wr_en(out_wr_en),
        .status(status), .branch_taken(branch_taken),
        .branch_target(branch_target), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] result;
        logic [3:0] rd;
        logic       wr_en;
    } entry_t;

    // Reference model state
    entry_t      q[$];
    entry_t      m_head;
    logic [3:0]  m_status;
    logic        m_taken;
    logic [7:0]  m_target;
    logic [15:0] m_retire;
    logic        m_ready;
    logic        s_ready;   // DUT in_ready sampled just before the edge

    int n_checks = 0;
    int n_fail   = 0;

    function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] s);
        bit fn, fz, fv, fc;
        fn = s[3]; fz = s[2]; fv = s[1]; fc = s[0];
        case (c)
            4'd0:    return 1'b1;
            4'd1:    return fz;
            4'd2:    return !fz;
            4'd3:    return fn != fv;
            4'd4:    return fn == fv;
            4'd5:    return !fz && (fn == fv);
            4'd6:    return fz || (fn != fv);
            4'd7:    return fc;
            4'd8:    return !fc;
            4'd9:    return fn;
            4'd10:   return !fn;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        q.delete();
        m_head   = '{8'h00, 4'h0, 1'b0};
        m_status = 4'b0000;
        m_taken  = 1'b0;
        m_target = 8'h00;
        m_retire = 16'h0000;
    endtask

    task automatic drive(input logic v, input logic [7:0] res, input logic [3:0] fl,
                         input logic sf, input logic we, input logic [3:0] rd,
                         input logic br, input logic [3:0] cond, input logic [7:0] tgt,
                         input logic fsh, input logic ordy);
        in_valid = v; in_result = res; in_flags = fl; in_set_flags = sf;
        in_wr_en = we; in_rd = rd; in_is_branch = br; in_cond = cond;
        in_target = tgt; flush = fsh; out_ready = ordy;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 8'h00, 1'b0, ordy);
    endtask

    // Advance model and DUT by one clock with the currently driven inputs.
    // Entered 1 time unit after a rising edge; leaves 1 unit after the next.
    task automatic step();
        bit acc, pp;
        #1;
        s_ready = in_ready;
        m_ready = (q.size() < 2) && !flush;
        acc = in_valid && m_ready;
        pp  = (q.size() > 0) && out_ready;
        m_taken = acc && in_is_branch && cond_ok(in_cond, m_status);
        if (m_taken) m_target = in_target;
        if (acc && in_set_flags) m_status = in_flags;
        if (pp) begin
            void'(q.pop_front());
            m_retire = m_retire + 16'd1;
        end
        if (flush) q.delete();
        if (acc) q.push_back('{in_result, in_rd, in_wr_en});
        if (q.size() > 0) m_head = q[0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(1'b0);
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_result !== 8'h00) begin n_fail++; $display("FAIL reset_out_result got=%h exp=00", out_result); end
        n_checks++; if (status !== 4'b0000) begin n_fail++; $display("FAIL reset_status got=%b exp=0000", status); end
        n_checks++; if (branch_taken !== 1'b0 || branch_target !== 8'h00) begin n_fail++; $display("FAIL reset_branch got=%b/%h exp=0/00", branch_taken, branch_target); end
        n_checks++; if (retire_count !== 16'h0000) begin n_fail++; $display("FAIL reset_retire got=%h exp=0000", retire_count); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        $display("reset: out_valid=%b status=%b retire=%h", out_valid, status, retire_count);
    endtask

    task automatic test_basic();
        drive(1'b1, 8'h05, 4'h0, 1'b0, 1'b1, 4'd3, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        step();
        idle(1'b1);
        n_checks++; if (out_valid !== 1'b1 || out_result !== 8'h05 || out_rd !== 4'd3 || out_wr_en !== 1'b1)
            begin n_fail++; $display("FAIL basic_head got=%b/%h/%h/%b exp=1/05/3/1", out_valid, out_result, out_rd, out_wr_en); end
        step();
        n_checks++; if (retire_count !== 16'd1 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL basic_retire got=%h/%b exp=0001/0", retire_count, out_valid); end
        n_checks++; if (out_result !== 8'h05)
            begin n_fail++; $display("FAIL basic_hold got=%h exp=05", out_result); end
        $display("basic: result=%h rd=%h retire=%h", out_result, out_rd, retire_count);
    endtask

    task automatic test_branch();
        drive(1'b1, 8'h11, 4'b0100, 1'b1, 1'b0, 4'd1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        step();
        n_checks++; if (status !== 4'b0100) begin n_fail++; $display("FAIL branch_status got=%b exp=0100", status); end
        drive(1'b1, 8'h22, 4'h0, 1'b0, 1'b0, 4'd2, 1'b1, 4'd1, 8'h40, 1'b0, 1'b1);
        step();
        n_checks++; if (branch_taken !== 1'b1 || branch_target !== 8'h40)
            begin n_fail++; $display("FAIL branch_eq got=%b/%h exp=1/40", branch_taken, branch_target); end
        drive(1'b1, 8'h33, 4'h0, 1'b0, 1'b0, 4'd2, 1'b1, 4'd2, 8'h80, 1'b0, 1'b1);
        step();
        n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL branch_pulse_ne got=%b exp=0", branch_taken); end
        idle(1'b1);
        step();
        n_checks++; if (branch_taken !== 1'b0) begin n_fail++; $display("FAIL branch_idle got=%b exp=0", branch_taken); end
        $display("branch: status=%b target=%h", status, branch_target);
    endtask

    task automatic test_same_instr();
        drive(1'b1, 8'h00, 4'b0000, 1'b1, 1'b0, 4'd0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        step();
        drive(1'b1, 8'h44, 4'b0100, 1'b1, 1'b0, 4'd0, 1'b1, 4'd1, 8'h50, 1'b0, 1'b1);
        step();
        n_checks++; if (branch_taken !== 1'b0 || status !== 4'b0100)
            begin n_fail++; $display("FAIL same_instr got=%b/%b exp=0/0100", branch_taken, status); end
        idle(1'b1);
        step();
        $display("same_instr: taken=%b status=%b", branch_taken, status);
    endtask

    task automatic test_back_to_back();
        logic [15:0] base;
        base = retire_count;
        drive(1'b1, 8'hA1, 4'h0, 1'b0, 1'b1, 4'd1, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hB2, 4'h0, 1'b0, 1'b1, 4'd2, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        step();
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2 got=%b exp=1", s_ready); end
        drive(1'b1, 8'hC3, 4'h0, 1'b0, 1'b1, 4'd3, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        step();
        n_checks++; if (s_ready !== 1'b0 || out_result !== 8'hA1)
            begin n_fail++; $display("FAIL b2b_full got=%b/%h exp=0/a1", s_ready, out_result); end
        out_ready = 1'b1;
        step();
        n_checks++; if (s_ready !== 1'b0 || out_result !== 8'hB2 || retire_count !== base + 16'd1)
            begin n_fail++; $display("FAIL b2b_pop1 got=%b/%h/%h exp=0/b2/%h", s_ready, out_result, retire_count, base + 16'd1); end
        step();
        n_checks++; if (s_ready !== 1'b1 || out_result !== 8'hC3 || out_rd !== 4'd3 || retire_count !== base + 16'd2)
            begin n_fail++; $display("FAIL b2b_pop2 got=%b/%h/%h/%h exp=1/c3/3/%h", s_ready, out_result, out_rd, retire_count, base + 16'd2); end
        idle(1'b1);
        step();
        n_checks++; if (out_valid !== 1'b0 || retire_count !== base + 16'd3)
            begin n_fail++; $display("FAIL b2b_drain got=%b/%h exp=0/%h", out_valid, retire_count, base + 16'd3); end
        $display("back_to_back: retire=%h", retire_count);
    endtask

    task automatic test_flush();
        logic [3:0] st;
        drive(1'b1, 8'h61, 4'h0, 1'b0, 1'b1, 4'd6, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0);
        step();
        step();
        st = status;
        drive(1'b1, 8'h77, 4'b1011, 1'b1, 1'b1, 4'd7, 1'b1, 4'd0, 8'h99, 1'b1, 1'b0);
        step();
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready got=%b exp=0", s_ready); end
        n_checks++; if (out_valid !== 1'b0 || status !== st || branch_taken !== 1'b0)
            begin n_fail++; $display("FAIL flush_state got=%b/%b/%b exp=0/%b/0", out_valid, status, branch_taken, st); end
        idle(1'b1);
        step();
        n_checks++; if (out_valid !== 1'b0 || retire_count !== m_retire)
            begin n_fail++; $display("FAIL flush_after got=%b/%h exp=0/%h", out_valid, retire_count, m_retire); end
        $display("flush: status=%b retire=%h", status, retire_count);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 4'($urandom), 1'($urandom),
                  1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom), 8'($urandom),
                  $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0);
            step();
            n_checks++; if (s_ready !== m_ready) begin n_fail++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", i, s_ready, m_ready); end
            n_checks++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_valid[%0d] got=%b exp=%0d", i, out_valid, q.size() > 0); end
            n_checks++; if (out_result !== m_head.result || out_rd !== m_head.rd || out_wr_en !== m_head.wr_en)
                begin n_fail++; $display("FAIL rnd_head[%0d] got=%h/%h/%b exp=%h/%h/%b", i, out_result, out_rd, out_wr_en, m_head.result, m_head.rd, m_head.wr_en); end
            n_checks++; if (status !== m_status) begin n_fail++; $display("FAIL rnd_status[%0d] got=%b exp=%b", i, status, m_status); end
            n_checks++; if (branch_taken !== m_taken || (m_taken && branch_target !== m_target))
                begin n_fail++; $display("FAIL rnd_branch[%0d] got=%b/%h exp=%b/%h", i, branch_taken, branch_target, m_taken, m_target); end
            n_checks++; if (retire_count !== m_retire) begin n_fail++; $display("FAIL rnd_retire[%0d] got=%h exp=%h", i, retire_count, m_retire); end
        end
        idle(1'b1);
        step();
        step();
        $display("random: retire=%h status=%b", retire_count, status);
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 8'h5A, 4'b1111, 1'b1, 1'b1, 4'd9, 1'b1, 4'd0, 8'h3C, 1'b0, 1'b0);
        step();
        drive(1'b1, 8'hA5, 4'b1001, 1'b1, 1'b1, 4'd10, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++; if (out_valid !== 1'b0 || out_result !== 8'h00 || out_rd !== 4'h0 || out_wr_en !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_fifo got=%b/%h/%h/%b exp=0/00/0/0", out_valid, out_result, out_rd, out_wr_en); end
        n_checks++; if (status !== 4'b0000 || branch_taken !== 1'b0 || branch_target !== 8'h00 || retire_count !== 16'h0000)
            begin n_fail++; $display("FAIL rstmid_regs got=%b/%b/%h/%h exp=0000/0/00/0000", status, branch_taken, branch_target, retire_count); end
        idle(1'b0);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (in_ready !== 1'b1 || retire_count !== 16'h0000 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL rstmid_release got=%b/%h/%b exp=1/0000/0", in_ready, retire_count, out_valid); end
        $display("reset_mid: in_ready=%b retire=%h", in_ready, retire_count);
    endtask

    task automatic test_wrap();
        drive(1'b1, 8'h0F, 4'h0, 1'b0, 1'b1, 4'd5, 1'b0, 4'h0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 70000 && m_retire != 16'hFFFF; i++) begin
            in_result = 8'(i);
            step();
        end
        n_checks++; if (retire_count !== 16'hFFFF || m_retire !== 16'hFFFF)
            begin n_fail++; $display("FAIL wrap_preload got=%h exp=ffff", retire_count); end
        idle(1'b1);
        step();
        n_checks++; if (retire_count !== 16'h0000)
            begin n_fail++; $display("FAIL wrap_zero got=%h exp=0000", retire_count); end
        $display("wrap: retire=%h", retire_count);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_same_instr();
        test_back_to_back();
        test_flush();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/exec_flag_unit.md
# exec_flag_unit

Execute-stage back end that consumes each ALU result and its 4-bit flag vector (bit3 N, bit2 Z, bit1 V, bit0 C). It maintains the architectural status register, resolves conditional branches against it, and buffers results in a 2-entry FIFO toward writeback with a valid/ready handshake. It sits between the ALU and the writeback stage.

## Interface
- N, 8, data width of result and branch target
- REGW, 4, destination register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream has an instruction
- in_ready  out  1  unit can accept this cycle
- in_result  in  N  ALU result
- in_flags  in  4  ALU flags {N,Z,V,C}
- in_set_flags  in  1  instruction updates status register
- in_wr_en  in  1  instruction writes a register
- in_rd  in  REGW  destination register index
- in_is_branch  in  1  instruction is a conditional branch
- in_cond  in  4  branch condition code
- in_target  in  N  branch target address
- flush  in  1  discard all buffered entries
- out_valid  out  1  writeback entry available
- out_ready  in  1  writeback consumes entry
- out_result  out  N  head entry result
- out_rd  out  REGW  head entry destination
- out_wr_en  out  1  head entry register write enable
- status  out  4  committed {N,Z,V,C}
- branch_taken  out  1  one-cycle taken pulse
- branch_target  out  N  target, valid while branch_taken=1
- retire_count  out  16  entries drained to writeback, wraps

## Operation
- Accept when in_valid & in_ready. in_ready = (count<2) & ~flush.
- On accept with in_set_flags=1: status <= in_flags. Otherwise status holds.
- On accept with in_is_branch=1: evaluate in_cond against status *before* this instruction's update, even when the same instruction sets flags.
- Taken → branch_taken=1 and branch_target=in_target on the next cycle, for one cycle only.
- Condition codes:
  - 0000 AL: 1
  - 0001 EQ: Z
  - 0010 NE: ~Z
  - 0011 LT: N^V
  - 0100 GE: ~(N^V)
  - 0101 GT: ~Z & ~(N^V)
  - 0110 LE: Z | (N^V)
  - 0111 CS: C
  - 1000 CC: ~C
  - 1001 MI: N
  - 1010 PL: ~N
  - 1011–1111: never taken
- Every accepted instruction, branch or not, is pushed into the FIFO as {result, rd, wr_en}. FIFO order is strict.
- Drain when out_valid & out_ready: pop the head and increment retire_count, which wraps 0xFFFF→0.
- FIFO boundaries:
  - count=2: no push.
  - count=0: out_valid=0. Out_* fields are don't-care but must not X-propagate; hold the last value.
  - Simultaneous push and pop at count=1: count stays 1 and the new entry becomes head next cycle.
- flush:
  - Next edge: count=0 and branch_taken=0.
  - No accept during the flush cycle.
  - A pop handshake in the flush cycle still counts as retired.
  - status and retire_count are otherwise unaffected.
- Reset (async assert, sync-deasserted externally): count=0, out_valid=0, out_result=0, out_rd=0, out_wr_en=0, status=0000, branch_taken=0, branch_target=0, retire_count=0. in_ready=1 once rst_n is high.

## Timing
- Accept at edge k: status updated and visible after k. Entry available as out_valid=1 after k if the FIFO was empty (1-cycle latency). branch_taken asserted in cycle k+1 only.
- Back-to-back accepts are allowed. A branch accepted at k+1 sees the status written at k.
- in_ready is combinational from count and flush only. out_* come directly from registers.
- Reset mid-operation discards all entries immediately; there is no partial drain.
- Throughput: 1 instruction/cycle while out_ready=1.

## Test plan
- Reset mid-traffic with 2 entries buffered → all outputs 0 immediately, in_ready=1 after release, retire_count=0.
- Accept result=0x05, rd=3, wr_en=1, then hold out_ready=1 → out_valid next cycle with out_result=0x05, out_rd=3, retire_count=1 after the pop.
- Flag-setting op with flags=0100, then EQ branch with target=0x40 → branch_taken=1 with target 0x40 for exactly one cycle. NE branch → not taken.
- Single branch with in_set_flags=1, in_flags=0100, cond=EQ, status=0000 → not taken; status becomes 0100.
- out_ready=0, push 3 back-to-back → in_ready drops after 2 accepts. Release out_ready → entries drain in order, retire_count=2, third accepted next.
- 2 entries buffered, flush=1 with in_valid=1 → no accept, count=0 next cycle, status unchanged. Preload retire_count=0xFFFF then drain 1 → wraps to 0x0000.
